// File: rtl/delay_pkg.sv
// Shared types and defaults for the random delay block.
package delay_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        FIRE  = 2'd2
    } delay_state_t;

    localparam int unsigned DEFAULT_WIDTH    = 8;
    localparam int unsigned DEFAULT_PRESCALE = 48;

endpackage

// File: rtl/delay_tick.sv
// Prescaler: counts enabled cycles 0..PRESCALE-1 and pulses tick on the last one.
module delay_tick #(
    parameter int unsigned PRESCALE = delay_pkg::DEFAULT_PRESCALE
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned PW = $clog2(PRESCALE + 1);

    logic [PW-1:0] cnt;

    assign tick = en && (cnt == PW'(PRESCALE - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + PW'(1);
        end
    end

endmodule

// File: rtl/random_delay.sv
// Captures an LFSR word as a tick count, waits that many prescaled ticks, then pulses time_out.
module random_delay
    import delay_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trigger,
    input  logic             abort,
    input  logic [WIDTH-1:0] seed,
    output logic             lfsr_en,
    output logic             busy,
    output logic             time_out,
    output logic [WIDTH-1:0] count
);

    delay_state_t     state, state_n;
    logic [WIDTH-1:0] count_n;
    logic             lfsr_en_n;
    logic             tick_clr;
    logic             tick;

    delay_tick #(
        .PRESCALE(PRESCALE)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (tick_clr),
        .en  (state == COUNT),
        .tick(tick)
    );

    assign busy     = (state != IDLE);
    assign time_out = (state == FIRE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            lfsr_en <= 1'b0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            lfsr_en <= lfsr_en_n;
        end
    end

    always_comb begin
        state_n   = state;
        count_n   = count;
        lfsr_en_n = 1'b0;
        tick_clr  = 1'b0;

        if (abort) begin
            // Abort overrides everything, including a same-cycle trigger in IDLE.
            state_n  = IDLE;
            count_n  = '0;
            tick_clr = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger) begin
                        count_n   = (seed == '0) ? WIDTH'(1) : seed;
                        tick_clr  = 1'b1;
                        lfsr_en_n = 1'b1;
                        state_n   = COUNT;
                    end
                end
                COUNT: begin
                    if (tick) begin
                        if (count > WIDTH'(1)) begin
                            count_n = count - WIDTH'(1);
                        end else begin
                            count_n = '0;
                            state_n = FIRE;
                        end
                    end
                end
                FIRE: begin
                    state_n = IDLE;
                end
                default: begin
                    state_n = IDLE;
                    count_n = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_random_delay.sv
// Directed self-checking bench for random_delay with PRESCALE=4.
module tb_random_delay;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned PRESCALE = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             trigger;
    logic             abort;
    logic [WIDTH-1:0] seed;
    logic             lfsr_en;
    logic             busy;
    logic             time_out;
    logic [WIDTH-1:0] count;

    int checks = 0;
    int errors = 0;

    random_delay #(
        .WIDTH   (WIDTH),
        .PRESCALE(PRESCALE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .trigger (trigger),
        .abort   (abort),
        .seed    (seed),
        .lfsr_en (lfsr_en),
        .busy    (busy),
        .time_out(time_out),
        .count   (count)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; trigger = 1'b0; abort = 1'b0; seed = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({lfsr_en, busy, time_out, count} !== 11'b0) begin
            errors++;
            $display("FAIL reset_state: got %b/%b/%b/%0d want 0/0/0/0", lfsr_en, busy, time_out, count);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // seed=5: count 5..1 every 4 cycles, time_out at T+21.
    task automatic test_basic();
        logic [WIDTH-1:0] exp_cnt;
        seed = 8'h05; trigger = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            trigger = 1'b0;
            exp_cnt = (k <= 20) ? WIDTH'(5 - (k - 1) / 4) : '0;
            checks++;
            if (lfsr_en !== (k == 1) || busy !== (k <= 21) || time_out !== (k == 21) || count !== exp_cnt) begin
                errors++;
                $display("FAIL basic k=%0d: got en=%b busy=%b to=%b cnt=%0d want en=%b busy=%b to=%b cnt=%0d",
                         k, lfsr_en, busy, time_out, count, k == 1, k <= 21, k == 21, exp_cnt);
            end
        end
    endtask

    // seed=0 behaves as one tick.
    task automatic test_zero_seed();
        seed = 8'h00; trigger = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            trigger = 1'b0;
            checks++;
            if (busy !== (k <= 5) || time_out !== (k == 5) || count !== ((k <= 4) ? 8'd1 : 8'd0)) begin
                errors++;
                $display("FAIL zero_seed k=%0d: got busy=%b to=%b cnt=%0d want busy=%b to=%b cnt=%0d",
                         k, busy, time_out, count, k <= 5, k == 5, (k <= 4) ? 1 : 0);
            end
        end
    endtask

    task automatic test_max_seed();
        logic [WIDTH-1:0] exp_cnt;
        seed = 8'hFF; trigger = 1'b1;
        for (int k = 1; k <= 1022; k++) begin
            @(negedge clk);
            trigger = 1'b0;
            exp_cnt = (k <= 1020) ? WIDTH'(255 - (k - 1) / 4) : '0;
            checks++;
            if (time_out !== (k == 1021) || busy !== (k <= 1021) || count !== exp_cnt) begin
                errors++;
                $display("FAIL max_seed k=%0d: got to=%b busy=%b cnt=%0d want to=%b busy=%b cnt=%0d",
                         k, time_out, busy, count, k == 1021, k <= 1021, exp_cnt);
            end
        end
    endtask

    task automatic test_abort();
        seed = 8'h05; trigger = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            trigger = 1'b0;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || count !== 8'd0 || time_out !== 1'b0) begin
            errors++;
            $display("FAIL abort_count: got busy=%b cnt=%0d to=%b want 0/0/0", busy, count, time_out);
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            checks++;
            if (time_out !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet k=%0d: got to=%b busy=%b want 0/0", k, time_out, busy);
            end
        end
    endtask

    task automatic test_abort_idle();
        seed = 8'h03; trigger = 1'b1; abort = 1'b1;
        @(negedge clk);
        trigger = 1'b0; abort = 1'b0;
        checks++;
        if (lfsr_en !== 1'b0 || busy !== 1'b0 || count !== 8'd0) begin
            errors++;
            $display("FAIL abort_idle: got en=%b busy=%b cnt=%0d want 0/0/0", lfsr_en, busy, count);
        end
    endtask

    // Abort during FIRE keeps the pulse already present.
    task automatic test_abort_fire();
        seed = 8'h00; trigger = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            trigger = 1'b0;
            abort = (k == 5);
            if (k == 5 || k == 6) begin
                checks++;
                if (time_out !== (k == 5) || busy !== (k == 5)) begin
                    errors++;
                    $display("FAIL abort_fire k=%0d: got to=%b busy=%b want %b/%b",
                             k, time_out, busy, k == 5, k == 5);
                end
            end
        end
        abort = 1'b0;
    endtask

    task automatic test_back_to_back();
        seed = 8'h02; trigger = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 19) trigger = 1'b0;
            checks++;
            if (time_out !== (k == 9 || k == 19) || busy !== (k != 10 && k != 20) ||
                lfsr_en !== (k == 1 || k == 11)) begin
                errors++;
                $display("FAIL back_to_back k=%0d: got to=%b busy=%b en=%b want to=%b busy=%b en=%b",
                         k, time_out, busy, lfsr_en, k == 9 || k == 19, k != 10 && k != 20, k == 1 || k == 11);
            end
        end
    endtask

    task automatic test_mid_reset();
        seed = 8'h05; trigger = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            trigger = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        trigger = 1'b1;
        checks++;
        if ({lfsr_en, busy, time_out, count} !== 11'b0) begin
            errors++;
            $display("FAIL mid_reset: got %b/%b/%b/%0d want 0/0/0/0", lfsr_en, busy, time_out, count);
        end
        @(negedge clk);
        rst = 1'b0; trigger = 1'b0;
        checks++;
        if ({lfsr_en, busy, time_out, count} !== 11'b0) begin
            errors++;
            $display("FAIL reset_trigger: got %b/%b/%b/%0d want 0/0/0/0", lfsr_en, busy, time_out, count);
        end
        @(negedge clk);
        seed = 8'h01; trigger = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            trigger = 1'b0;
            checks++;
            if (time_out !== (k == 5) || lfsr_en !== (k == 1)) begin
                errors++;
                $display("FAIL after_reset k=%0d: got to=%b en=%b want %b/%b", k, time_out, lfsr_en, k == 5, k == 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_seed();
        test_max_seed();
        test_abort();
        test_abort_idle();
        test_abort_fire();
        repeat (2) @(negedge clk);
        test_back_to_back();
        @(negedge clk);
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
